mod_n_updown_counter: RTL
=========================

// Module: mod_n_updown_counter
// PURPOSE
//  Runtime-programmable modulus up/down counter with sync clear, parallel load,
//  cascade carry and optional saturation. Chaining instances (tc -> next en)
//  builds real-time timekeepers (e.g. mod-60 sec -> mod-60 min -> mod-24 hr).
//  It is the parametrised successor of the fixed mod-N counter: direction,
//  modulus and wrap/saturate mode are selectable.
// PARAMETERS
//  N_MAX    60              largest supported modulus (>= 2)
//  W        $clog2(N_MAX)   count/load width
//  MW       $clog2(N_MAX+1) modulus input width
//  SATURATE 0               0 = wrap at terminal; 1 = hold at terminal
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  clear      in   1   synchronous clear to 0, highest priority
//  load       in   1   synchronous parallel load of load_data
//  en         in   1   count enable / cascade carry-in
//  up_dn      in   1   1 = count up, 0 = count down
//  modulus    in   MW  active modulus M; values 0..1 act as M=1; values > N_MAX act as N_MAX
//  load_data  in   W   value to load
//  count      out  W   current count, registered
//  tc         out  1   combinational terminal count (cascade carry-out)
//  wrap       out  1   registered 1-cycle pulse after a wrap (or saturation hit)
//  sat        out  1   registered sticky flag, SATURATE=1 only; else tied 0
// BEHAVIOUR
//  - Reset (reset_n=0, async): count=0, wrap=0, sat=0. Release is sampled at the
//    next rising edge.
//  - Effective modulus Me = clamp(modulus, 1, N_MAX). It is sampled every cycle
//    with no pipeline.
//  - Terminal value T = Me-1 when up_dn=1, 0 when up_dn=0.
//  - tc = en & ~clear & ~load & (count == T). It is combinational, same cycle.
//  - Priority per edge: clear > load > en. When none is active, count holds.
//  - clear: count<=0; sat<=0; wrap<=0.
//  - load: count <= (load_data >= Me) ? Me-1 : load_data. wrap<=0. sat is unchanged.
//  - en, up: count==T -> wrap to 0 (SATURATE=0) or hold (SATURATE=1).
//    count>T (modulus shrank) -> 0. Otherwise count+1.
//  - en, down: count==0 -> Me-1 (SATURATE=0) or hold (SATURATE=1).
//    count>Me-1 -> Me-1. Otherwise count-1.
//  - wrap <= 1 for exactly one cycle after an en step taken at count==T,
//    otherwise 0. With SATURATE=1 it pulses on every enabled cycle spent at T.
//  - sat (SATURATE=1): set on the first enabled step at T. Cleared only by
//    clear or reset.
//  - Me=1: count is forced to 0. tc = en every cycle. wrap pulses on each en.
//  - up_dn may change on any cycle. The step always uses the current-cycle value.
//  - Latency: count updates one clock after the qualifying inputs.
//  - No combinational path from tc to en inside the block. Cascade tc->en is
//    legal; chain depth limits fmax.
//  - Counter arithmetic is in W+1 bits internally. It never produces a value >= Me.
// TESTING
//  1 Reset: assert reset_n=0 mid-count at count=7.
//    -> count=0, wrap=0 immediately, without waiting for a clock edge.
//  2 Up wrap, M=10, en=1: counts 0..9.
//    -> tc=1 while count=9; next count=0; wrap=1 for one cycle.
//  3 Down wrap, M=10, up_dn=0, start 0, en=1.
//    -> tc=1 at 0; next count=9; wrap pulse.
//  4 Priority: clear=1, load=1 (data 5), en=1 at count 3.
//    -> count=0, tc=0.
//  5 Load clamp, M=6: load_data=9.
//    -> count=5.
//  6 Modulus shrink: count=8, modulus changed to 4, en=1, up.
//    -> count=0.
//  7 Cascade: mod-60 feeds mod-60 feeds mod-24 (each stage en = previous tc).
//    Start at 23:59:59, one en.
//    -> all stages 0; each stage's wrap pulses the same cycle.
//  8 SATURATE=1, M=4, up, en held for 6 cycles.
//    -> count stops at 3; sat=1 from the cycle after first reaching terminal;
//    clear -> count=0, sat=0.

Source files
------------

// File: rtl/mod_n_updown_counter_if.sv
// mod_n_updown_counter_if: control, data and status bundle of the mod-N up/down counter
interface mod_n_updown_counter_if #(
    parameter int N_MAX = 60
);
    localparam int W = $clog2(N_MAX);
    localparam int MW = $clog2(N_MAX + 1);
    logic clear;
    logic load;
    logic en;
    logic up_dn;
    logic [MW-1:0] modulus;
    logic [W-1:0] load_data;
    logic [W-1:0] count;
    logic tc;
    logic wrap;
    logic sat;
    modport master (
        output clear, load, en, up_dn, modulus, load_data,
        input count, tc, wrap, sat
    );
    modport slave (
        input clear, load, en, up_dn, modulus, load_data,
        output count, tc, wrap, sat
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: runtime-modulus up/down counter with clear, load, cascade carry and optional saturation
module mod_n_updown_counter #(
    parameter int N_MAX = 60,
    parameter bit SATURATE = 1'b0
) (
    input logic clk,
    input logic reset_n,
    mod_n_updown_counter_if.slave bus
);
    localparam int W = $clog2(N_MAX);
    localparam int MW = $clog2(N_MAX + 1);
    logic [W:0] me, top, term, cur;
    logic [W-1:0] ld, nxt, count_q;
    logic wrap_q, sat_q, at_t;
    always_comb begin
        me = (bus.modulus < MW'(2)) ? (W+1)'(1) :
             (bus.modulus > MW'(N_MAX)) ? (W+1)'(N_MAX) : (W+1)'(bus.modulus);
        top = me - (W+1)'(1);
        cur = {1'b0, count_q};
        term = bus.up_dn ? top : '0;
        at_t = cur == term;
        ld = ({1'b0, bus.load_data} >= me) ? top[W-1:0] : bus.load_data;
        // a count left above the terminal by a shrinking modulus re-enters the valid range
        nxt = bus.up_dn
            ? ((cur > top) ? '0 : at_t ? (SATURATE ? count_q : '0) : count_q + W'(1))
            : ((cur > top) ? top[W-1:0] : at_t ? (SATURATE ? count_q : top[W-1:0]) : count_q - W'(1));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (bus.clear) begin
            count_q <= '0;
            wrap_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (bus.load) begin
            count_q <= ld;
            wrap_q <= 1'b0;
        end else if (bus.en) begin
            count_q <= nxt;
            wrap_q <= at_t;
            if (SATURATE && at_t) sat_q <= 1'b1;
        end else begin
            wrap_q <= 1'b0;
        end
    end
    assign bus.count = count_q;
    assign bus.tc = bus.en & ~bus.clear & ~bus.load & at_t;
    assign bus.wrap = wrap_q;
    assign bus.sat = SATURATE & sat_q;
endmodule
